// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle for the icache.
// The slave modport is the cache's view; master is the IF stage plus memory controller.
interface icache_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_pc;
    logic              if_clear;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic              mem_rn;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ready;
    logic [31:0]       mem_value;

    modport master (
        output if_req, if_pc, if_clear, mem_ready, mem_value,
        input  if_valid, if_inst, mem_rn, mem_addr
    );

    modport slave (
        input  if_req, if_pc, if_clear, mem_ready, mem_value,
        output if_valid, if_inst, mem_rn, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with single-word miss fills.
// Optional macro ICACHE_FLUSH_EN adds a fence_i input that invalidates every line.
module icache #(
    parameter int INDEX_W = 8,
    parameter int ADDR_W  = 32
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  rdy,
`ifdef ICACHE_FLUSH_EN
    input  logic  fence_i,
`endif
    icache_if.slave bus
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [1:0] {IDLE, MISS, RESP, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [31:0]       data_q [LINES];
    logic              resp_q, resp_d;
    logic [31:0]       inst_q, inst_d;
    logic              mem_rn_q, mem_rn_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic [INDEX_W-1:0] req_idx, fill_idx;
    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic               hit, accept, fill_we, flush_now;
    logic               unused_pc_lsbs;

    assign req_idx        = bus.if_pc[INDEX_W+1:2];
    assign req_tag        = bus.if_pc[ADDR_W-1:INDEX_W+2];
    assign unused_pc_lsbs = ^bus.if_pc[1:0];
    // The latched miss address doubles as the fill address for the line being refilled.
    assign fill_idx       = mem_addr_q[INDEX_W+1:2];
    assign fill_tag       = mem_addr_q[ADDR_W-1:INDEX_W+2];
    assign hit            = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

`ifdef ICACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    assign flush_now = (state_q == IDLE) && (fence_i || flush_pend_q);

    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == IDLE)
            flush_pend_d = 1'b0;
        else if (fence_i)
            flush_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            flush_pend_q <= 1'b0;
        else if (rdy)
            flush_pend_q <= flush_pend_d;
    end
`else
    assign flush_now = 1'b0;
`endif

    // While a response is on the bus IF still holds the old pc, so it must not be re-sampled.
    assign accept = (state_q == IDLE) && bus.if_req && !bus.if_clear && !resp_q && !flush_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            resp_q     <= 1'b0;
            inst_q     <= '0;
            mem_rn_q   <= 1'b0;
            mem_addr_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            inst_q     <= inst_d;
            mem_rn_q   <= mem_rn_d;
            mem_addr_q <= mem_addr_d;
            if (flush_now)
                valid_q <= '0;
            else if (fill_we)
                valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.mem_value;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !hit) state_d = MISS;
            MISS: begin
                if (bus.mem_ready)
                    state_d = bus.if_clear ? IDLE : RESP;
                else if (bus.if_clear)
                    state_d = DRAIN;
            end
            RESP:    state_d = IDLE;
            DRAIN:   if (bus.mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_d     = 1'b0;
        inst_d     = inst_q;
        mem_rn_d   = mem_rn_q;
        mem_addr_d = mem_addr_q;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && hit) begin
                    resp_d = 1'b1;
                    inst_d = data_q[req_idx];
                end else if (accept) begin
                    mem_rn_d   = 1'b1;
                    mem_addr_d = {bus.if_pc[ADDR_W-1:2], 2'b00};
                end
            end
            MISS, DRAIN: begin
                // A drained fill still lands in the array; only the response is dropped.
                if (bus.mem_ready) begin
                    fill_we  = 1'b1;
                    mem_rn_d = 1'b0;
                    if (state_q == MISS && !bus.if_clear) begin
                        resp_d = 1'b1;
                        inst_d = bus.mem_value;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.if_valid = resp_q & rdy & ~bus.if_clear;
    assign bus.if_inst  = inst_q;
    assign bus.mem_rn   = mem_rn_q;
    assign bus.mem_addr = mem_addr_q;
endmodule
